maze_env_responder: RTL and testbench

Sequential maze environment answering action requests from the Q-learning agent. Accepts one action per valid/ready handshake, moves an internal 8x8 position register, and returns next state, signed reward and an episode-done flag over a second valid/ready handshake. Sits between the agent and the reward/state path as the environment end of the agent's action-request interface; the agent initiates and this block responds.

---
 rtl/maze_env_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_maze_env_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_env_responder.sv
// -----------------------------------------------------------------------------
// maze_env_responder
//
// Environment side of the Q-learning agent's action-request interface. The
// agent hands over one action per act_valid/act_ready handshake. The block
// moves an internal position on an 8x8 grid and answers with next state,
// signed reward and an episode-done flag over a resp_valid/resp_ready
// handshake.
//
// Optional feature macro: MAZE_STEP_LIMIT_EN
//   defined   -> an 8-bit per-episode step counter ends the episode after
//                MAX_STEPS moves, in addition to reaching GOAL_STATE.
//   undefined -> the episode ends only when GOAL_STATE is entered.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   act_valid      in   1   agent presents an action
//   act_ready      out  1   block can accept an action (IDLE only)
//   action         in   4   one-hot: 0001 up, 0010 down, 0100 left, 1000 right
//   resp_valid     out  1   response fields valid (RESP only)
//   resp_ready     in   1   agent accepts the response
//   next_state     out  6   {row[2:0], col[2:0]} after the move
//   next_reward    out  16  signed two's-complement reward
//   done           out  1   episode ended with this response
//   current_state  out  6   position register, always visible
//   episode_cnt    out  16  completed episodes, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module maze_env_responder #(
  parameter logic [5:0]         START_STATE = 6'd0,
  parameter logic [5:0]         GOAL_STATE  = 6'd63,
  parameter logic [63:0]        WALL_MAP    = 64'h0,
  parameter logic signed [15:0] R_GOAL      = 16'sd100,
  parameter logic signed [15:0] R_WALL      = -16'sd10,
  parameter logic signed [15:0] R_STEP      = -16'sd1,
  parameter logic [7:0]         MAX_STEPS   = 8'd64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [3:0]         action,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [5:0]         next_state,
  output logic signed [15:0] next_reward,
  output logic               done,
  output logic [5:0]         current_state,
  output logic [15:0]        episode_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]         action_reg;
  logic [5:0]         cur_reg;
  logic [5:0]         ns_reg;
  logic signed [15:0] rew_reg;
  logic               done_reg;
  logic [15:0]        ep_reg;

  // Move evaluation (combinational, consumed in COMPUTE)
  logic [2:0]         row;
  logic [2:0]         col;
  logic [5:0]         cand;
  logic               off_grid;
  logic               illegal;
  logic               blocked;
  logic               hit_goal;
  logic [5:0]         ns_next;
  logic signed [15:0] rew_next;
  logic               done_next;

  // Handshake qualifiers
  logic act_fire;
  logic resp_fire;
  logic episode_end;

  assign act_fire    = (state_reg == IDLE) && act_valid;
  assign resp_fire   = (state_reg == RESP) && resp_ready;
  assign episode_end = resp_fire && done_reg;

  // ---------------------------------------------------------------------------
  // Candidate move. Row 0 is the top of the grid, so "up" decrements the row.
  // The candidate index is computed even for off-grid moves (it wraps); it is
  // never used in that case because off_grid forces the blocked path.
  // ---------------------------------------------------------------------------
  assign row = cur_reg[5:3];
  assign col = cur_reg[2:0];

  always_comb begin
    cand     = cur_reg;
    off_grid = 1'b0;
    illegal  = 1'b0;
    case (action_reg)
      4'b0001: begin
        off_grid = (row == 3'd0);
        cand     = {row - 3'd1, col};
      end
      4'b0010: begin
        off_grid = (row == 3'd7);
        cand     = {row + 3'd1, col};
      end
      4'b0100: begin
        off_grid = (col == 3'd0);
        cand     = {row, col - 3'd1};
      end
      4'b1000: begin
        off_grid = (col == 3'd7);
        cand     = {row, col + 3'd1};
      end
      default: begin
        // Zero or multiple bits set: not a valid move.
        illegal = 1'b1;
      end
    endcase
  end

  assign blocked  = off_grid || illegal || WALL_MAP[cand];
  assign hit_goal = !blocked && (cand == GOAL_STATE);

  always_comb begin
    ns_next  = cand;
    rew_next = R_STEP;
    if (blocked) begin
      ns_next  = cur_reg;
      rew_next = R_WALL;
    end else if (hit_goal) begin
      rew_next = R_GOAL;
    end
  end

`ifdef MAZE_STEP_LIMIT_EN
  // ---------------------------------------------------------------------------
  // Per-episode step counter. The comparison uses the incremented value so
  // the MAX_STEPS-th move of an episode is the one that reports done. A goal
  // hit already ends the episode, so the limit only adds the timeout case;
  // the reward for that move is unchanged.
  // ---------------------------------------------------------------------------
  logic [7:0] step_reg;
  logic [7:0] step_inc;

  assign step_inc  = step_reg + 8'd1;
  assign done_next = hit_goal || (step_inc == MAX_STEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg <= 8'd0;
    end else if (state_reg == COMPUTE) begin
      step_reg <= step_inc;
    end else if (episode_end) begin
      step_reg <= 8'd0;
    end
  end
`else
  // Without the step limit, only the goal ends an episode.
  logic [7:0] unused_max_steps;

  assign unused_max_steps = MAX_STEPS;
  assign done_next        = hit_goal;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    act_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        act_ready = 1'b1;
        if (act_valid) begin
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. The response fields only load in COMPUTE, so they stay
  // stable for as long as the agent stalls in RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      action_reg <= 4'd0;
      cur_reg    <= START_STATE;
      ns_reg     <= START_STATE;
      rew_reg    <= 16'sd0;
      done_reg   <= 1'b0;
      ep_reg     <= 16'd0;
    end else begin
      if (act_fire) begin
        action_reg <= action;
      end

      if (state_reg == COMPUTE) begin
        ns_reg   <= ns_next;
        rew_reg  <= rew_next;
        done_reg <= done_next;
        cur_reg  <= ns_next;
      end

      // The agent has seen the terminal response: start the next episode.
      if (episode_end) begin
        cur_reg <= START_STATE;
        ep_reg  <= ep_reg + 16'd1;
      end
    end
  end

  assign next_state    = ns_reg;
  assign next_reward   = rew_reg;
  assign done          = done_reg;
  assign current_state = cur_reg;
  assign episode_cnt   = ep_reg;

endmodule

// File: tb/tb_maze_env_responder.sv
// -----------------------------------------------------------------------------
// tb_maze_env_responder
//
// Directed bench for maze_env_responder. Two instances share clock, reset,
// action and resp_ready, and each has its own act_valid:
//   u0: default parameters (empty map)
//   u1: WALL_MAP bit 8 set, MAX_STEPS = 4 (step limit active only when
//       MAZE_STEP_LIMIT_EN is defined)
// The bench prints one line per transaction and one summary line at the end.
// -----------------------------------------------------------------------------
module tb_maze_env_responder;

  localparam logic [3:0]  UP    = 4'b0001;
  localparam logic [3:0]  DOWN  = 4'b0010;
  localparam logic [3:0]  LEFT  = 4'b0100;
  localparam logic [3:0]  RIGHT = 4'b1000;

  // Expected rewards as raw 16-bit patterns.
  localparam logic [15:0] E_GOAL = 16'h0064;  // +100
  localparam logic [15:0] E_WALL = 16'hFFF6;  // -10
  localparam logic [15:0] E_STEP = 16'hFFFF;  // -1

  logic        clk;
  logic        rst_n;
  logic [3:0]  action;
  logic        resp_ready;
  logic        av [2];
  logic        ar [2];
  logic        rv [2];
  logic [5:0]  ns [2];
  logic [15:0] rw [2];
  logic        dn [2];
  logic [5:0]  cs [2];
  logic [15:0] ep [2];

  int checks   = 0;
  int failures = 0;

  maze_env_responder u0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .act_valid     (av[0]),
    .act_ready     (ar[0]),
    .action        (action),
    .resp_valid    (rv[0]),
    .resp_ready    (resp_ready),
    .next_state    (ns[0]),
    .next_reward   (rw[0]),
    .done          (dn[0]),
    .current_state (cs[0]),
    .episode_cnt   (ep[0])
  );

  maze_env_responder #(
    .WALL_MAP  (64'h0000_0000_0000_0100),
    .MAX_STEPS (8'd4)
  ) u1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .act_valid     (av[1]),
    .act_ready     (ar[1]),
    .action        (action),
    .resp_valid    (rv[1]),
    .resp_ready    (resp_ready),
    .next_state    (ns[1]),
    .next_reward   (rw[1]),
    .done          (dn[1]),
    .current_state (cs[1]),
    .episode_cnt   (ep[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge. Performs one action handshake on instance
  // s and checks the response. With rr = 1 the response is accepted and the
  // task returns #1 after the acceptance edge; with rr = 0 it returns #1 after
  // the edge that entered RESP, leaving the response pending.
  task automatic do_act(input int s, input logic [3:0] a, input logic rr,
                        input logic [5:0] e_ns, input logic [15:0] e_rw,
                        input logic e_dn);
    int n;
    n = 0;
    resp_ready = rr;
    while (ar[s] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("act_ready_before_accept", ar[s], 1'b1);
    action = a;
    av[s]  = 1'b1;
    @(posedge clk);          // accept edge N
    #1;
    av[s]  = 1'b0;
    chk("compute_resp_valid_low", rv[s], 1'b0);
    chk("compute_act_ready_low", ar[s], 1'b0);
    @(posedge clk);          // edge N+1: response registered
    #1;
    chk("resp_valid_high", rv[s], 1'b1);
    chk("next_state", ns[s], e_ns);
    chk("next_reward", rw[s], e_rw);
    chk("done", dn[s], e_dn);
    chk("current_state_after_compute", cs[s], e_ns);
    $display("txn u%0d action=%b next_state=%0d reward=%0d done=%0b",
             s, a, ns[s], $signed(rw[s]), dn[s]);
    if (rr) begin
      @(posedge clk);        // edge N+2: response accepted
      #1;
      chk("resp_valid_after_accept", rv[s], 1'b0);
      chk("act_ready_after_accept", ar[s], 1'b1);
      if (e_dn) begin
        chk("current_state_restart", cs[s], 6'd0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    action     = 4'b0000;
    resp_ready = 1'b0;
    av[0]      = 1'b0;
    av[1]      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values
    chk("rst_act_ready", ar[0], 1'b1);
    chk("rst_resp_valid", rv[0], 1'b0);
    chk("rst_next_state", ns[0], 6'd0);
    chk("rst_next_reward", rw[0], 16'h0000);
    chk("rst_done", dn[0], 1'b0);
    chk("rst_current_state", cs[0], 6'd0);
    chk("rst_episode_cnt", ep[0], 16'd0);

    // Basic moves and rejected moves from the corner
    do_act(0, RIGHT, 1'b1, 6'd1, E_STEP, 1'b0);
    do_act(0, LEFT,  1'b1, 6'd0, E_STEP, 1'b0);
    do_act(0, UP,    1'b1, 6'd0, E_WALL, 1'b0);   // off top edge
    do_act(0, LEFT,  1'b1, 6'd0, E_WALL, 1'b0);   // off left edge
    do_act(0, 4'b0011, 1'b1, 6'd0, E_WALL, 1'b0); // two bits set
    do_act(0, 4'b0000, 1'b1, 6'd0, E_WALL, 1'b0); // no bit set

    // Walk down the left column to row 7, bump the bottom edge, then right to 62
    for (int r = 1; r < 8; r++) begin
      do_act(0, DOWN, 1'b1, 6'(r * 8), E_STEP, 1'b0);
    end
    do_act(0, DOWN, 1'b1, 6'd56, E_WALL, 1'b0);
    for (int c = 1; c < 7; c++) begin
      do_act(0, RIGHT, 1'b1, 6'(56 + c), E_STEP, 1'b0);
    end
    do_act(0, RIGHT, 1'b1, 6'd63, E_GOAL, 1'b1);
    chk("episode_cnt_after_goal", ep[0], 16'd1);

    // Stall in RESP for 5 cycles while a second action is offered
    do_act(0, RIGHT, 1'b0, 6'd1, E_STEP, 1'b0);
    for (int k = 0; k < 5; k++) begin
      action = LEFT;
      av[0]  = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_resp_valid", rv[0], 1'b1);
      chk("stall_act_ready", ar[0], 1'b0);
      chk("stall_next_state", ns[0], 6'd1);
      chk("stall_next_reward", rw[0], E_STEP);
      chk("stall_current_state", cs[0], 6'd1);
    end
    av[0]      = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_resp_valid", rv[0], 1'b0);
    chk("stall_release_act_ready", ar[0], 1'b1);
    @(posedge clk);
    #1;
    chk("stall_extra_action_ignored", cs[0], 6'd1);
    chk("stall_no_new_compute", ar[0], 1'b1);

    // Asynchronous reset while a response is pending
    do_act(0, RIGHT, 1'b0, 6'd2, E_STEP, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", rv[0], 1'b0);
    chk("mid_rst_current_state", cs[0], 6'd0);
    chk("mid_rst_episode_cnt", ep[0], 16'd0);
    chk("mid_rst_act_ready", ar[0], 1'b1);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_response", rv[0], 1'b0);
    end

    // Step limit on u1: alternate right/left from 0
    for (int i = 0; i < 4; i++) begin
`ifdef MAZE_STEP_LIMIT_EN
      do_act(1, (i % 2 == 0) ? RIGHT : LEFT, 1'b1,
             (i % 2 == 0) ? 6'd1 : 6'd0, E_STEP, (i == 3));
`else
      do_act(1, (i % 2 == 0) ? RIGHT : LEFT, 1'b1,
             (i % 2 == 0) ? 6'd1 : 6'd0, E_STEP, 1'b0);
`endif
    end
    chk("limit_current_state", cs[1], 6'd0);
`ifdef MAZE_STEP_LIMIT_EN
    chk("limit_episode_cnt", ep[1], 16'd1);
`else
    chk("limit_episode_cnt", ep[1], 16'd0);
`endif

    // Wall at cell 8 blocks the move down from 0 on u1; u0 moves freely
    do_act(1, DOWN, 1'b1, 6'd0, E_WALL, 1'b0);
    do_act(0, DOWN, 1'b1, 6'd8, E_STEP, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
